// File: rtl/frame_stuffer_tx.sv
// frame_stuffer_tx: serializes one latched parallel frame byte by byte,
// escapes flag/escape bytes and wraps the stream in FRAME_START/FRAME_END.
module frame_stuffer_tx #(
    parameter int DATA_SIZE       = 64,
    parameter int PREAMBLE_SIZE   = 7,
    parameter int CRC_SIZE        = 4,
    parameter logic [7:0] FRAME_START = 8'h06,
    parameter logic [7:0] FRAME_END   = 8'h07,
    parameter logic [7:0] ESC_VAL     = 8'h14,
    parameter logic [7:0] ESC_XOR     = 8'h20,
    localparam int FRAME_BYTES    = PREAMBLE_SIZE + DATA_SIZE + CRC_SIZE,
    localparam int FRAME_SIZE     = FRAME_BYTES * 8 - 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [0:FRAME_SIZE] fin,
    input  logic                fin_valid,
    output logic                busy,
    output logic [7:0]          tx_byte,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                done,
    output logic                drop
);

    localparam int IDX_W = $clog2(FRAME_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        BODY,
        ESC2,
        END
    } state_t;

    state_t             state_q, state_n;
    logic [IDX_W-1:0]   idx_q, idx_n;
    logic [0:FRAME_SIZE] frame_q, frame_n;
    logic [7:0]         tx_byte_q, tx_byte_n;
    logic               tx_valid_q, tx_valid_n;
    logic               done_q, done_n;
    logic               drop_q, drop_n;
    logic               accept;
    logic               advance;
    logic [7:0]         cur_byte;
    logic [7:0]         nxt_byte;

    // Bytes that collide with the framing alphabet must be escaped.
    function automatic logic is_special(input logic [7:0] b);
        return (b == FRAME_START) || (b == FRAME_END) || (b == ESC_VAL);
    endfunction

    // The holding register shifts left one byte per advance, so the
    // byte at idx always sits in the top byte lane.
    assign cur_byte = frame_q[0:7];
    assign nxt_byte = frame_q[8:15];
    assign accept   = tx_valid_q && tx_ready;

    assign busy     = (state_q != IDLE);
    assign tx_byte  = tx_byte_q;
    assign tx_valid = tx_valid_q;
    assign done     = done_q;
    assign drop     = drop_q;

    // State register; every output is registered so tx_byte holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            frame_q    <= '0;
            tx_byte_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_n;
            idx_q      <= idx_n;
            frame_q    <= frame_n;
            tx_byte_q  <= tx_byte_n;
            tx_valid_q <= tx_valid_n;
            done_q     <= done_n;
            drop_q     <= drop_n;
        end
    end

    // Next-state logic: on each accepted byte, load the following byte so
    // the stream runs one byte per clock with no bubble.
    always_comb begin
        state_n    = state_q;
        idx_n      = idx_q;
        frame_n    = frame_q;
        tx_byte_n  = tx_byte_q;
        tx_valid_n = tx_valid_q;
        done_n     = 1'b0;
        drop_n     = 1'b0;
        advance    = 1'b0;

        case (state_q)
            IDLE: begin
                tx_valid_n = 1'b0;
                if (fin_valid) begin
                    frame_n    = fin;
                    idx_n      = '0;
                    state_n    = START;
                    tx_byte_n  = FRAME_START;
                    tx_valid_n = 1'b1;
                end
            end
            START: begin
                if (accept) begin
                    state_n   = BODY;
                    tx_byte_n = is_special(cur_byte) ? ESC_VAL : cur_byte;
                end
            end
            BODY: begin
                if (accept) begin
                    if (is_special(cur_byte)) begin
                        state_n   = ESC2;
                        tx_byte_n = cur_byte ^ ESC_XOR;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            ESC2: begin
                if (accept) begin
                    advance = 1'b1;
                end
            end
            END: begin
                if (accept) begin
                    state_n    = IDLE;
                    tx_valid_n = 1'b0;
                    done_n     = 1'b1;
                end
            end
            default: begin
                state_n    = IDLE;
                tx_valid_n = 1'b0;
            end
        endcase

        if (advance) begin
            if (idx_q == LAST_IDX) begin
                state_n   = END;
                tx_byte_n = FRAME_END;
            end else begin
                state_n   = BODY;
                idx_n     = idx_q + IDX_W'(1);
                frame_n   = {frame_q[8:FRAME_SIZE], 8'h00};
                tx_byte_n = is_special(nxt_byte) ? ESC_VAL : nxt_byte;
            end
        end

        if (fin_valid && (state_q != IDLE)) begin
            drop_n = 1'b1;
        end
    end

endmodule

// File: tb/tb_frame_stuffer_tx.sv
// Directed self-checking bench for frame_stuffer_tx.
module tb_frame_stuffer_tx;

    localparam int FRAME_BYTES = 75;
    localparam int FRAME_SIZE  = FRAME_BYTES * 8 - 1;

    typedef logic [7:0] byte_q_t[$];

    logic                clk;
    logic                rst;
    logic [0:FRAME_SIZE] fin;
    logic                fin_valid;
    logic                busy;
    logic [7:0]          tx_byte;
    logic                tx_valid;
    logic                tx_ready;
    logic                done;
    logic                drop;

    int check_cnt;
    int pass_cnt;
    int cyc;
    int done_cnt;
    int drop_cnt;
    int first_xfer;
    int last_xfer;
    int done_cycle;
    int stab_errors;
    bit rand_ready;
    logic [7:0] cap[$];
    logic       prev_valid;
    logic       prev_ready;
    logic [7:0] prev_byte;

    frame_stuffer_tx dut (
        .clk       (clk),
        .rst       (rst),
        .fin       (fin),
        .fin_valid (fin_valid),
        .busy      (busy),
        .tx_byte   (tx_byte),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .done      (done),
        .drop      (drop)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Sink readiness changes just after each rising edge.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor on the falling edge: log transfers, pulses and hold violations.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_valid <= 1'b0;
        end else begin
            if (prev_valid && !prev_ready && (!tx_valid || tx_byte != prev_byte))
                stab_errors++;
            if (tx_valid && tx_ready) begin
                cap.push_back(tx_byte);
                if (first_xfer < 0) first_xfer = cyc;
                last_xfer = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cycle = cyc;
            end
            if (drop) drop_cnt++;
            prev_valid <= tx_valid;
            prev_ready <= tx_ready;
            prev_byte  <= tx_byte;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_cnt++;
        if (actual === expected) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    endtask

    task automatic clearLog();
        cap.delete();
        first_xfer = -1;
        last_xfer  = -1;
        done_cnt   = 0;
        drop_cnt   = 0;
        done_cycle = -1;
    endtask

    // Offer a frame for a single cycle.
    task automatic applyStimulus(input logic [0:FRAME_SIZE] f);
        @(posedge clk);
        #1;
        fin       = f;
        fin_valid = 1'b1;
        @(posedge clk);
        #1;
        fin_valid = 1'b0;
    endtask

    task automatic waitDones(input int target, input int max_cycles);
        int n;
        n = 0;
        while (done_cnt < target && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt < target) checkOutput("timeout_done", done_cnt, target);
    endtask

    // Reference stuffing model built straight from the framing rules.
    task automatic buildExpected(input logic [0:FRAME_SIZE] f, output byte_q_t q);
        logic [7:0] b;
        q = {};
        q.push_back(8'h06);
        for (int k = 0; k < FRAME_BYTES; k++) begin
            b = f[8*k +: 8];
            if (b == 8'h06 || b == 8'h07 || b == 8'h14) begin
                q.push_back(8'h14);
                q.push_back(b ^ 8'h20);
            end else begin
                q.push_back(b);
            end
        end
        q.push_back(8'h07);
    endtask

    task automatic compareStream(input string tag, input byte_q_t exp_q);
        int mism;
        int n;
        mism = 0;
        n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (cap[i] !== exp_q[i]) mism++;
        checkOutput({tag, "_len"}, cap.size(), exp_q.size());
        checkOutput({tag, "_bytes"}, mism, 0);
    endtask

    logic [0:FRAME_SIZE] frame_a5;
    logic [0:FRAME_SIZE] frame_esc;
    logic [0:FRAME_SIZE] frame_33;
    logic [0:FRAME_SIZE] frame_11;
    byte_q_t exp_q;
    int wait_n;

    initial begin
        check_cnt   = 0;
        pass_cnt    = 0;
        cyc         = 0;
        stab_errors = 0;
        rand_ready  = 1'b0;
        prev_valid  = 1'b0;
        prev_ready  = 1'b0;
        prev_byte   = 8'h00;
        fin         = '0;
        fin_valid   = 1'b0;
        clearLog();

        for (int k = 0; k < FRAME_BYTES; k++) begin
            frame_a5[8*k +: 8] = 8'hA5;
            frame_33[8*k +: 8] = 8'h33;
            frame_11[8*k +: 8] = 8'h11;
            frame_esc[8*k +: 8] = 8'h00;
        end
        frame_esc[0 +: 8]  = 8'h06;
        frame_esc[80 +: 8] = 8'h07;
        frame_esc[592 +: 8] = 8'h14;

        // Reset state
        rst = 1'b1;
        #1;
        checkOutput("rst_tx_valid", tx_valid, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_tx_byte", tx_byte, 8'h00);
        checkOutput("rst_pulses", {done, drop}, 2'b00);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        // Plain frame, back-pressure free
        clearLog();
        applyStimulus(frame_a5);
        checkOutput("plain_busy", busy, 1'b1);
        waitDones(1, 300);
        buildExpected(frame_a5, exp_q);
        compareStream("plain", exp_q);
        checkOutput("plain_count", cap.size(), 77);
        checkOutput("plain_contig", last_xfer - first_xfer, 76);
        checkOutput("plain_done_lag", done_cycle - last_xfer, 1);
        if (cap.size() == 77) begin
            checkOutput("plain_first", cap[0], 8'h06);
            checkOutput("plain_last", cap[76], 8'h07);
        end
        #1;
        checkOutput("plain_idle_busy", busy, 1'b0);

        // Escaped frame, back-pressure free
        clearLog();
        applyStimulus(frame_esc);
        waitDones(1, 300);
        checkOutput("esc_count", cap.size(), 80);
        if (cap.size() == 80) begin
            checkOutput("esc_b1", cap[1], 8'h14);
            checkOutput("esc_b2", cap[2], 8'h26);
            checkOutput("esc_b12", cap[12], 8'h14);
            checkOutput("esc_b13", cap[13], 8'h27);
            checkOutput("esc_b77", cap[77], 8'h14);
            checkOutput("esc_b78", cap[78], 8'h34);
        end
        buildExpected(frame_esc, exp_q);
        compareStream("esc", exp_q);

        // Same escaped frame under random back-pressure
        clearLog();
        stab_errors = 0;
        rand_ready = 1'b1;
        applyStimulus(frame_esc);
        waitDones(1, 2000);
        rand_ready = 1'b0;
        compareStream("rand", exp_q);
        checkOutput("rand_stable", stab_errors, 0);

        // Frame offered while busy is ignored
        clearLog();
        applyStimulus(frame_a5);
        wait_n = 0;
        while (cap.size() < 20 && wait_n < 200) begin
            @(negedge clk);
            wait_n++;
        end
        applyStimulus(frame_33);
        waitDones(1, 300);
        repeat (100) @(negedge clk);
        buildExpected(frame_a5, exp_q);
        compareStream("drop", exp_q);
        checkOutput("drop_pulses", drop_cnt, 1);
        checkOutput("drop_dones", done_cnt, 1);

        // Reset while the escaped byte is pending
        clearLog();
        @(posedge clk);
        #1;
        fin = frame_esc;
        fin_valid = 1'b1;
        @(posedge clk);
        #1;
        fin_valid = 1'b0;
        wait_n = 0;
        while (!(tx_valid && tx_ready && tx_byte == 8'h14) && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_tx_valid", tx_valid, 1'b0);
        checkOutput("midrst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_no_done", done_cnt, 0);
        clearLog();
        applyStimulus(frame_11);
        waitDones(1, 300);
        buildExpected(frame_11, exp_q);
        compareStream("after_rst", exp_q);
        if (cap.size() >= 2) begin
            checkOutput("after_rst_b0", cap[0], 8'h06);
            checkOutput("after_rst_b1", cap[1], 8'h11);
        end

        // fin_valid held high: back-to-back frames, one idle cycle apart
        clearLog();
        @(posedge clk);
        #1;
        fin = frame_a5;
        fin_valid = 1'b1;
        wait_n = 0;
        while (done_cnt < 3 && wait_n < 600) begin
            @(negedge clk);
            #1;
            wait_n++;
        end
        fin_valid = 1'b0;
        if (done_cnt < 3) checkOutput("timeout_b2b", done_cnt, 3);
        repeat (100) @(negedge clk);
        checkOutput("b2b_dones", done_cnt, 3);
        checkOutput("b2b_count", cap.size(), 231);
        checkOutput("b2b_gaps", last_xfer - first_xfer + 1 - 231, 2);
        if (cap.size() == 231) begin
            checkOutput("b2b_f2_start", cap[77], 8'h06);
            checkOutput("b2b_f3_end", cap[230], 8'h07);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
